// File: rtl/bitcell_pkg.sv
// rtl/bitcell_pkg.sv - shared state type, default settle time and row-count helper
package bitcell_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_SEL,
        R_SAMPLE
    } ctrl_state_t;

    localparam int SETTLE_DEFAULT = 1;

    // Number of rows addressed by an addr_w-bit row address (every address is a real row).
    function automatic int rows_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/bitcell_row_decoder.sv
// rtl/bitcell_row_decoder.sv - row address to one-hot select, forced to all-zero when disabled
module bitcell_row_decoder
    import bitcell_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int ROWS   = rows_of(ADDR_W)
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ROWS-1:0]   sel_o
);

    always_comb begin
        sel_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (en_i && (addr_i == ADDR_W'(r))) begin
                sel_o[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// rtl/bitcell_array_ctrl.sv - sequences host requests into glitch-safe sel/r_w/in strobes for a NAND-latch bitcell array
module bitcell_array_ctrl
    import bitcell_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int SETTLE  = SETTLE_DEFAULT,
    localparam int ROWS   = rows_of(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ROWS-1:0]   arr_sel,
    output logic              arr_r_w,
    output logic [DATA_W-1:0] arr_in,
    input  logic [DATA_W-1:0] arr_out
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    ctrl_state_t       state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              arr_r_w_q;
    logic [DATA_W-1:0] arr_in_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              sel_en;

    // arr_r_w/arr_in only move in IDLE, W_SETUP entry or W_HOLD exit, where sel is already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            arr_r_w_q   <= 1'b0;
            arr_in_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (req_we) begin
                            state_q   <= W_SETUP;
                            arr_r_w_q <= 1'b1;
                            arr_in_q  <= req_wdata;
                        end else begin
                            state_q <= R_SEL;
                            cnt_q   <= SETTLE_LOAD;
                        end
                    end
                end
                W_SETUP: begin
                    state_q <= W_STROBE;
                    cnt_q   <= SETTLE_LOAD;
                end
                W_STROBE: begin
                    if (cnt_q == 4'd0) state_q <= W_HOLD;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                W_HOLD: begin
                    state_q   <= IDLE;
                    arr_r_w_q <= 1'b0;
                end
                R_SEL: begin
                    if (cnt_q == 4'd0) state_q <= R_SAMPLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                R_SAMPLE: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= arr_out;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_en = (state_q == W_STROBE) || (state_q == R_SEL) || (state_q == R_SAMPLE);

    bitcell_row_decoder #(
        .ADDR_W (ADDR_W),
        .ROWS   (ROWS)
    ) u_row_decoder (
        .en_i   (sel_en),
        .addr_i (addr_q),
        .sel_o  (arr_sel)
    );

    assign req_ready = (state_q == IDLE);
    assign arr_r_w   = arr_r_w_q;
    assign arr_in    = arr_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb/tb_bitcell_array_ctrl.sv - self-checking bench for bitcell_array_ctrl built with SETTLE=1 and SETTLE=3
`timescale 1ns/1ps
module tb_bitcell_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int S = (g == 0) ? 1 : 3;

        logic       rst_n = 1'b1;
        logic       req_valid = 1'b0;
        logic       req_we = 1'b0;
        logic [1:0] req_addr = 2'd0;
        logic [7:0] req_wdata = 8'h00;
        logic       req_ready, rsp_valid, arr_r_w;
        logic [7:0] rsp_rdata, arr_in, arr_out;
        logic [3:0] arr_sel;
        logic [7:0] mem [4] = '{default: 8'h00};
        bit         done = 1'b0;

        bitcell_array_ctrl #(.ADDR_W(2), .DATA_W(8), .SETTLE(S)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .arr_sel   (arr_sel),
            .arr_r_w   (arr_r_w),
            .arr_in    (arr_in),
            .arr_out   (arr_out)
        );

        // Bitcell array: bitlines are the OR of selected rows in read mode; a selected row in write mode follows arr_in.
        always_comb begin
            arr_out = 8'h00;
            for (int r = 0; r < 4; r++)
                if (arr_sel[r] && !arr_r_w) arr_out = arr_out | mem[r];
        end
        always @(negedge clk)
            for (int r = 0; r < 4; r++)
                if (arr_sel[r] && arr_r_w) mem[r] = arr_in;

        // Transaction model: k is the cycle number counted from the acceptance edge.
        bit         busy = 1'b0, m_we = 1'b0, m_rsp = 1'b0, was_idle;
        int         k = 0, acc_cnt = 0, cyc = 0;
        logic [1:0] m_addr = 2'd0;
        logic [7:0] m_in = 8'h00, m_rdata = 8'h00;

        always @(posedge clk) cyc++;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy = 1'b0; k = 0; m_in = 8'h00; m_rdata = 8'h00; m_rsp = 1'b0;
            end else begin
                was_idle = !busy;
                m_rsp = 1'b0;
                if (busy) begin
                    k++;
                    if (k == (m_we ? S + 3 : S + 2)) begin
                        busy = 1'b0;
                        if (!m_we) begin m_rsp = 1'b1; m_rdata = mem[m_addr]; end
                    end
                end
                if (was_idle && req_valid) begin
                    busy = 1'b1; k = 1; m_we = req_we; m_addr = req_addr;
                    if (req_we) m_in = req_wdata;
                    acc_cnt++;
                end
            end
        end

        logic [3:0] e_sel, prev_sel = 4'd0;
        logic       prev_rw = 1'b0, prev_ok = 1'b0;
        logic [7:0] prev_in = 8'h00;

        always @(negedge clk) begin
            e_sel = 4'd0;
            if (busy && ((m_we && k >= 2 && k <= S + 1) || (!m_we && k <= S + 1)))
                e_sel = 4'b0001 << m_addr;
            chk("arr_sel", g, arr_sel, e_sel);
            chk("arr_r_w", g, arr_r_w, busy && m_we);
            chk("arr_in", g, arr_in, m_in);
            chk("req_ready", g, req_ready, !busy);
            chk("rsp_valid", g, rsp_valid, m_rsp);
            chk("rsp_rdata", g, rsp_rdata, m_rdata);
            if (rst_n) begin
                chk("sel_onehot", g, $countones(arr_sel) <= 1, 1'b1);
                if (prev_ok && (prev_sel != 4'd0 || arr_sel != 4'd0))
                    chk("rw_in_stable_under_sel", g, {arr_r_w, arr_in}, {prev_rw, prev_in});
                if (prev_ok && prev_sel != 4'd0 && arr_sel != 4'd0)
                    chk("sel_no_row_hop", g, arr_sel, prev_sel);
            end
            prev_ok = rst_n; prev_sel = arr_sel; prev_rw = arr_r_w; prev_in = arr_in;
        end

        logic [3:0] o_sel [1:12];
        logic       o_rw [1:12], o_rdy [1:12], o_rsp [1:12];

        task automatic wait_acc(input int c0, output int lat);
            bit ok = 1'b0;
            lat = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                lat++;
                ok = (acc_cnt != c0);
            end
            if (!ok) chk("accept_timeout", g, acc_cnt, c0 + 1);
        endtask

        task automatic record();
            for (int i = 1; i <= 12; i++) begin
                if (i > 1) @(negedge clk);
                o_sel[i] = arr_sel; o_rw[i] = arr_r_w; o_rdy[i] = req_ready; o_rsp[i] = rsp_valid;
            end
        endtask

        task automatic issue(input bit we, input logic [1:0] a, input logic [7:0] wd);
            int c0, lat;
            c0 = acc_cnt;
            req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
            wait_acc(c0, lat);
            req_valid = 1'b0;
            record();
        endtask

        function automatic int first_ready();
            for (int i = 1; i <= 12; i++) if (o_rdy[i]) return i;
            return 0;
        endfunction
        function automatic int first_rsp();
            for (int i = 1; i <= 12; i++) if (o_rsp[i]) return i;
            return 0;
        endfunction
        function automatic int n_sel();
            int n = 0;
            for (int i = 1; i <= 12; i++) if (o_sel[i] != 4'd0) n++;
            return n;
        endfunction
        function automatic int n_rsp();
            int n = 0;
            for (int i = 1; i <= 12; i++) if (o_rsp[i]) n++;
            return n;
        endfunction
        function automatic int n_rw();
            int n = 0;
            for (int i = 1; i <= 12; i++) if (o_rw[i]) n++;
            return n;
        endfunction

        initial begin
            int c0, lat, cyc0;
            // Reset held with a write request pending.
            #1 rst_n = 1'b0;
            req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd2; req_wdata = 8'hA5;
            repeat (3) @(negedge clk);
            chk("rst_sel", g, arr_sel, 4'b0000);
            chk("rst_rw", g, arr_r_w, 1'b0);
            chk("rst_in", g, arr_in, 8'h00);
            chk("rst_rsp", g, rsp_valid, 1'b0);
            chk("rst_no_accept", g, acc_cnt, 0);

            // Release with the A5 write already presented: taken on the first edge.
            rst_n = 1'b1;
            c0 = acc_cnt;
            wait_acc(c0, lat);
            req_valid = 1'b0;
            chk("first_edge_accept", g, lat, 1);
            chk("first_edge_ready", g, req_ready, 1'b0);
            record();
            chk("w_c1_rw", g, o_rw[1], 1'b1);
            chk("w_c1_sel", g, o_sel[1], 4'b0000);
            chk("w_c2_sel", g, o_sel[2], 4'b0100);
            chk("w_hold_sel", g, o_sel[S + 2], 4'b0000);
            chk("w_hold_rw", g, o_rw[S + 2], 1'b1);
            chk("w_ready_at", g, first_ready(), (g == 0) ? 4 : 6);
            chk("w_sel_cycles", g, n_sel(), (g == 0) ? 1 : 3);
            chk("w_in_held", g, arr_in, 8'hA5);
            chk("w_mem2", g, mem[2], 8'hA5);

            // Read row 2 with junk write data.
            issue(1'b0, 2'd2, 8'hFF);
            chk("r_rsp_at", g, first_rsp(), (g == 0) ? 3 : 5);
            chk("r_rsp_pulses", g, n_rsp(), 1);
            chk("r_data", g, rsp_rdata, 8'hA5);
            chk("r_sel_cycles", g, n_sel(), (g == 0) ? 2 : 4);
            chk("r_rw_never", g, n_rw(), 0);
            chk("r_mem2_kept", g, mem[2], 8'hA5);

            // Back-to-back: write 3C row 1, read row 1 with req_valid never dropped.
            req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 8'h3C;
            c0 = acc_cnt;
            wait_acc(c0, lat);
            cyc0 = cyc;
            req_we = 1'b0; req_wdata = 8'h00;
            wait_acc(c0 + 1, lat);
            req_valid = 1'b0;
            chk("b2b_read_gap", g, cyc - cyc0, (g == 0) ? 4 : 6);
            record();
            chk("b2b_rsp_at", g, first_rsp(), (g == 0) ? 3 : 5);
            chk("b2b_data", g, rsp_rdata, 8'h3C);

            // Reset during W_STROBE of a write to row 0.
            req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'h77;
            c0 = acc_cnt;
            wait_acc(c0, lat);
            req_valid = 1'b0;
            @(posedge clk);
            #2;
            chk("abort_pre_sel", g, arr_sel, 4'b0001);
            rst_n = 1'b0;
            #1;
            chk("abort_sel_drop", g, arr_sel, 4'b0000);
            chk("abort_no_rsp", g, rsp_valid, 1'b0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            issue(1'b1, 2'd3, 8'h0F);
            issue(1'b0, 2'd3, 8'h00);
            chk("post_abort_rsp_at", g, first_rsp(), (g == 0) ? 3 : 5);
            chk("post_abort_data", g, rsp_rdata, 8'h0F);
            repeat (2) @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (inst[0].done && inst[1].done) break;
        end
        if (!(inst[0].done && inst[1].done)) begin
            errors++;
            checks++;
            $display("FAIL bench_timeout: done=%0b%0b required 11", inst[0].done, inst[1].done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitcell_array_ctrl.md
# bitcell_array_ctrl

Sequencing controller that turns host read/write requests into safe sel / r_w / in strobes for a row-addressed array of NAND-latch bitcells, and returns read data. It sits between a host valid/ready request port and the bitcell array. Its timing keeps each level-sensitive latch from capturing glitches: data and r_w are stable before sel rises and remain stable until after sel falls.

## Interface
- ADDR_W, 2: row address width; ROWS = 2**ADDR_W rows.
- DATA_W, 8: bitcells per row (word width).
- SETTLE, 1: cycles sel is held before a write completes or read data is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  host request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target row.
- req_wdata  in  DATA_W  write data; ignored on reads.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid while it is high.
- rsp_rdata  out  DATA_W  read data; holds its last value otherwise.
- arr_sel  out  ROWS  one-hot row select; all-zero when idle.
- arr_r_w  out  1  array write enable: 1 = write, 0 = read.
- arr_in  out  DATA_W  data to the array write inputs (shared across rows).
- arr_out  in  DATA_W  array read bitlines; unselected rows drive 0, so the bitlines are the OR of all rows.

## Operation
- A request is accepted on a rising edge when req_valid && req_ready. The controller latches req_we, req_addr and req_wdata on that edge.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SEL, R_SAMPLE.
- Write path: IDLE → W_SETUP (1 cycle) → W_STROBE (SETTLE cycles) → W_HOLD (1 cycle) → IDLE.
  - W_SETUP: arr_r_w=1, arr_in=wdata, arr_sel=0.
  - W_STROBE: arr_sel=onehot(addr); arr_r_w and arr_in unchanged.
  - W_HOLD: arr_sel=0; arr_r_w and arr_in held.
- Read path: IDLE → R_SEL (SETTLE cycles) → R_SAMPLE (1 cycle) → IDLE.
  - Both states drive arr_r_w=0 and arr_sel=onehot(addr).
  - arr_out is registered into rsp_rdata at the end of R_SAMPLE.
  - rsp_valid is 1 during the following IDLE cycle.
- In IDLE: arr_sel=0, arr_r_w=0, and arr_in holds its last value.
- req_ready = (state == IDLE). A new request may be accepted in the same cycle that rsp_valid is high.
- rsp_valid has no backpressure.
- Invariants the implementation must hold:
  - arr_sel is never more than one-hot.
  - arr_r_w and arr_in never change in a cycle where arr_sel ≠ 0.
  - arr_sel never changes directly from one nonzero value to another.
- Every address is legal, because ROWS = 2**ADDR_W.

## Timing
- Reset (rst_n low) forces the following asynchronously: state=IDLE, arr_sel=0, arr_r_w=0, arr_in=0, rsp_valid=0, rsp_rdata=0, settle counter=0.
- No request is accepted while rst_n is low.
- Write: busy for SETTLE+2 cycles after the acceptance edge. req_ready is high again in cycle SETTLE+3.
- Read: rsp_valid is high in cycle SETTLE+2 after the acceptance edge (cycle 3 when SETTLE=1).
- Reset mid-operation: arr_sel drops immediately and no rsp_valid is issued. A write aborted during W_STROBE leaves that row undefined; the host must rewrite it.
- The settle counter is 4 bits. It loads SETTLE−1 on entry to W_STROBE or R_SEL and exits the state at 0.

## Structure
- Package bitcell_pkg holds:
  - the state enum (ctrl_state_t);
  - the default SETTLE constant;
  - the onehot/ROWS helper function, shared with the array top level.
- Sub-module bitcell_row_decoder: ADDR_W → ROWS one-hot, with an enable input (outputs all-zero when the enable is low). It is combinational. The controller drives its enable from (state ∈ {W_STROBE, R_SEL, R_SAMPLE}).
- The FSM, settle counter and data registers live in bitcell_array_ctrl.

## Test plan
1. Reset: hold rst_n=0 with req_valid=1, req_we=1 → arr_sel=0, arr_r_w=0, rsp_valid=0, and no acceptance. After release, the first request is accepted on the first edge.
2. Write 0xA5 to row 2 (SETTLE=1):
   - cycle 1: arr_r_w=1, arr_in=0xA5, arr_sel=0;
   - cycle 2: arr_sel=4'b0100;
   - cycle 3: arr_sel=0, arr_in=0xA5;
   - req_ready returns to 1 in cycle 4.
3. Read row 2 against a behavioural bitcell-array model, with req_wdata=0xFF → rsp_rdata=0xA5 and rsp_valid high for exactly one cycle, 3 cycles after acceptance. arr_r_w=0 throughout; the model contents are unchanged.
4. Back-to-back traffic with req_valid held high: write 0x3C to row 1, then read row 1 → the read is accepted on the first IDLE cycle and returns 0x3C. An assertion monitor sees no multi-hot arr_sel and no arr_r_w or arr_in change while arr_sel≠0.
5. Reset mid-operation: drop rst_n during W_STROBE → arr_sel=0 at the same time step and no rsp_valid. After release, writing 0x0F to row 3 and reading it back returns 0x0F.
6. SETTLE=3 build → write busy for 5 cycles, read rsp_valid at cycle 5, and arr_sel high for 3 write cycles / 4 read cycles.
